// File: rtl/bcd_display_scheduler.sv
// Round-robin scheduler that shares one external binary-to-BCD converter among
// NUM_CH channels, clamping each sample to 999 and latching per-channel digits.
module bcd_display_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic [12*NUM_CH-1:0]      ch_data,
    output logic [11:0]               conv_data,
    input  logic [3:0]                conv_d100,
    input  logic [3:0]                conv_d10,
    input  logic [3:0]                conv_d,
    output logic [12*NUM_CH-1:0]      digits,
    output logic [NUM_CH-1:0]         valid,
    output logic [NUM_CH-1:0]         ovf,
    output logic                      done,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_ch
);
    localparam int              CH_W     = $clog2(NUM_CH);
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE_CYCLES);
    localparam logic [11:0]     MAX_DEC  = 12'd999;
    localparam logic [CH_W:0]   NUM_CH_C = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_CAPTURE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] clr_s;
    logic [CH_W-1:0]   rr_ptr_r;
    logic [CH_W-1:0]   pick_s;
    logic [CH_W:0]     sum_s;
    logic [CH_W-1:0]   idx_s;
    logic [3:0]        cnt_r;
    logic              grant_s;
    logic              capture_s;
    logic [11:0]       sel_data_s;

    // Round-robin pick: scan from farthest to nearest offset so the nearest pending channel wins.
    always_comb begin
        pick_s = rr_ptr_r;
        sum_s  = '0;
        idx_s  = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            sum_s  = {1'b0, rr_ptr_r} + (CH_W+1)'(off);
            idx_s  = (sum_s >= NUM_CH_C) ? CH_W'(sum_s - NUM_CH_C) : sum_s[CH_W-1:0];
            pick_s = pending_r[idx_s] ? idx_s : pick_s;
        end
    end

    // Next-state logic and grant/capture strobes.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|pending_r) begin
                    state_next_s = ST_WAIT;
                    grant_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == SETTLE_C) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                capture_s    = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Selected channel sample and the pending bit cleared on its grant.
    always_comb begin
        sel_data_s = ch_data[int'(pick_s) * 12 +: 12];
        if (grant_s) begin
            clr_s = ONE_HOT0 << pick_s;
        end else begin
            clr_s = '0;
        end
    end

    // Control state: FSM, settle counter, request latch and round-robin pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            pending_r <= '0;
            rr_ptr_r  <= '0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            busy      <= (state_next_s != ST_IDLE);
            // A new request on the grant cycle survives the clear.
            pending_r <= (pending_r & ~clr_s) | req;
            if (grant_s) begin
                cnt_r <= 4'd0;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (capture_s) begin
                rr_ptr_r <= (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1'b1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Grant snapshot: channel index, clamped converter input and overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_ch  <= '0;
            conv_data <= 12'd0;
            ovf       <= '0;
        end else if (grant_s) begin
            grant_ch      <= pick_s;
            conv_data     <= (sel_data_s > MAX_DEC) ? MAX_DEC : sel_data_s;
            ovf[pick_s]   <= (sel_data_s > MAX_DEC);
        end else begin
            grant_ch  <= grant_ch;
            conv_data <= conv_data;
            ovf       <= ovf;
        end
    end

    // Capture converter digits into the serviced channel's slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digits <= '0;
            valid  <= '0;
            done   <= 1'b0;
        end else begin
            done <= capture_s;
            if (capture_s) begin
                digits[int'(grant_ch) * 12 +: 12] <= {conv_d100, conv_d10, conv_d};
                valid[grant_ch]                   <= 1'b1;
            end else begin
                digits <= digits;
                valid  <= valid;
            end
        end
    end

endmodule
